// File: rtl/regfile_wb_scheduler.sv
// Round-robin arbiter sharing the register-file write port between ALU (A) and load (B) writebacks.
// The write port is registered one cycle after the grant. Ready is combinational, and a loser keeps valid until granted.
module regfile_wb_scheduler #(
  parameter int DW    = 32,
  parameter int AW    = 4,
  parameter int NREGS = 16,
  parameter int RO_LO = 14,
  parameter int RO_HI = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic [AW-1:0]    issue_dreg,
  input  logic             a_valid,
  input  logic [AW-1:0]    a_dreg,
  input  logic [DW-1:0]    a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [AW-1:0]    b_dreg,
  input  logic [DW-1:0]    b_data,
  output logic             b_ready,
  output logic             rf_we,
  output logic [AW-1:0]    rf_dreg,
  output logic [DW-1:0]    rf_wdata,
  input  logic [AW-1:0]    rd_op1,
  input  logic [AW-1:0]    rd_op2,
  output logic             hazard1,
  output logic             hazard2,
  output logic [NREGS-1:0] pending,
  output logic [7:0]       drop_count
);

  typedef struct packed {
    logic [AW-1:0] dreg;
    logic [DW-1:0] data;
  } wb_t;

  function automatic logic is_ro(input logic [AW-1:0] r);
    return (r == AW'(RO_LO)) || (r == AW'(RO_HI));
  endfunction

  // prio_q: 0 = A wins the next contested cycle, 1 = B wins it
  logic             prio_q, prio_d;
  logic             rf_we_q, rf_we_d;
  wb_t              rf_q, rf_d;
  logic [NREGS-1:0] pending_q, pending_d;
  logic [7:0]       drop_q, drop_d;

  logic grant_a, grant_b, xfer, contested;
  wb_t  sel;

  always_comb begin
    contested = a_valid && b_valid;
    grant_a   = !reset && a_valid && (!b_valid || !prio_q);
    grant_b   = !reset && b_valid && (!a_valid || prio_q);
    xfer      = grant_a || grant_b;
    sel       = grant_b ? '{dreg: b_dreg, data: b_data} : '{dreg: a_dreg, data: a_data};
  end

  always_comb begin
    prio_d    = (contested && !reset) ? !prio_q : prio_q;
    rf_we_d   = xfer && !is_ro(sel.dreg);
    rf_d      = xfer ? sel : rf_q;
    drop_d    = drop_q;
    if (xfer && is_ro(sel.dreg) && drop_q != 8'hFF)
      drop_d = drop_q + 8'd1;

    // Clear before set so a new producer issued alongside the retiring write stays outstanding.
    pending_d = pending_q;
    if (xfer)
      pending_d[sel.dreg] = 1'b0;
    if (issue_valid && !is_ro(issue_dreg))
      pending_d[issue_dreg] = 1'b1;
    pending_d[RO_LO] = 1'b0;
    pending_d[RO_HI] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q    <= 1'b0;
      rf_we_q   <= 1'b0;
      rf_q      <= '0;
      pending_q <= '0;
      drop_q    <= '0;
    end else begin
      prio_q    <= prio_d;
      rf_we_q   <= rf_we_d;
      rf_q      <= rf_d;
      pending_q <= pending_d;
      drop_q    <= drop_d;
    end
  end

  assign a_ready    = grant_a;
  assign b_ready    = grant_b;
  assign rf_we      = rf_we_q;
  assign rf_dreg    = rf_q.dreg;
  assign rf_wdata   = rf_q.data;
  assign pending    = pending_q;
  assign drop_count = drop_q;
  assign hazard1    = pending_q[rd_op1];
  assign hazard2    = pending_q[rd_op2];

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler with hand-computed expectations.
module tb_regfile_wb_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic [3:0]  issue_dreg;
  logic        a_valid, b_valid;
  logic [3:0]  a_dreg, b_dreg;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready;
  logic        rf_we;
  logic [3:0]  rf_dreg;
  logic [31:0] rf_wdata;
  logic [3:0]  rd_op1, rd_op2;
  logic        hazard1, hazard2;
  logic [15:0] pending;
  logic [7:0]  drop_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_wb_scheduler dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_dreg(issue_dreg),
    .a_valid(a_valid), .a_dreg(a_dreg), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_dreg(b_dreg), .b_data(b_data), .b_ready(b_ready),
    .rf_we(rf_we), .rf_dreg(rf_dreg), .rf_wdata(rf_wdata),
    .rd_op1(rd_op1), .rd_op2(rd_op2), .hazard1(hazard1), .hazard2(hazard2),
    .pending(pending), .drop_count(drop_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    logic exp_a;
    logic [31:0] a_cnt, b_cnt;
    int we_cnt;

    reset = 1'b1; issue_valid = 1'b0; issue_dreg = '0;
    a_valid = 1'b0; a_dreg = '0; a_data = '0;
    b_valid = 1'b0; b_dreg = '0; b_data = '0;
    rd_op1 = '0; rd_op2 = '0;
    tick(); tick();
    chk("rst_a_ready", 32'(a_ready), 32'd0);
    chk("rst_b_ready", 32'(b_ready), 32'd0);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_rf_dreg", 32'(rf_dreg), 32'd0);
    chk("rst_rf_wdata", rf_wdata, 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    reset = 1'b0;

    // Single A writeback
    a_valid = 1'b1; a_dreg = 4'd3; a_data = 32'hDEADBEEF;
    settle();
    chk("t1_a_ready", 32'(a_ready), 32'd1);
    chk("t1_b_ready", 32'(b_ready), 32'd0);
    tick();
    a_valid = 1'b0;
    chk("t1_we", 32'(rf_we), 32'd1);
    chk("t1_dreg", 32'(rf_dreg), 32'd3);
    chk("t1_wdata", rf_wdata, 32'hDEADBEEF);
    tick();
    chk("t1_we_off", 32'(rf_we), 32'd0);
    chk("t1_dreg_hold", 32'(rf_dreg), 32'd3);

    // Contention: A,B,A,B with fresh data after each grant
    a_cnt = 32'hA000_0000; b_cnt = 32'hB000_0000; we_cnt = 0;
    a_valid = 1'b1; a_dreg = 4'd1; a_data = a_cnt;
    b_valid = 1'b1; b_dreg = 4'd2; b_data = b_cnt;
    for (int i = 0; i < 4; i++) begin
      exp_a = (i % 2 == 0);
      settle();
      chk("ct_a_ready", 32'(a_ready), 32'(exp_a));
      chk("ct_b_ready", 32'(b_ready), 32'(!exp_a));
      chk("ct_onehot", 32'(a_ready && b_ready), 32'd0);
      tick();
      if (rf_we) we_cnt++;
      chk("ct_dreg", 32'(rf_dreg), exp_a ? 32'd1 : 32'd2);
      chk("ct_wdata", rf_wdata, exp_a ? a_cnt : b_cnt);
      if (exp_a) begin a_cnt = a_cnt + 1; a_data = a_cnt; end
      else       begin b_cnt = b_cnt + 1; b_data = b_cnt; end
    end
    a_valid = 1'b0; b_valid = 1'b0;
    chk("ct_we_count", 32'(we_cnt), 32'd4);
    tick();

    // Scoreboard
    issue_valid = 1'b1; issue_dreg = 4'd5; rd_op1 = 4'd5; rd_op2 = 4'd6;
    tick();
    issue_valid = 1'b0;
    settle();
    chk("sb_pending5", 32'(pending), 32'h20);
    chk("sb_hazard1", 32'(hazard1), 32'd1);
    chk("sb_hazard2", 32'(hazard2), 32'd0);
    b_valid = 1'b1; b_dreg = 4'd5; b_data = 32'h55;
    settle();
    chk("sb_b_ready", 32'(b_ready), 32'd1);
    tick();
    b_valid = 1'b0;
    settle();
    chk("sb_clear", 32'(pending), 32'h0);
    chk("sb_hazard1_clr", 32'(hazard1), 32'd0);
    chk("sb_we", 32'(rf_we), 32'd1);
    issue_valid = 1'b1; issue_dreg = 4'd5;
    tick();
    b_valid = 1'b1; b_dreg = 4'd5; b_data = 32'h56;
    tick();
    issue_valid = 1'b0; b_valid = 1'b0;
    chk("sb_set_wins", 32'(pending), 32'h20);
    b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
    chk("sb_clear2", 32'(pending), 32'h0);

    // Read-only destinations
    a_valid = 1'b1; a_dreg = 4'd14; a_data = 32'h1414;
    settle();
    chk("ro_a_ready", 32'(a_ready), 32'd1);
    tick();
    a_valid = 1'b0;
    chk("ro_we14", 32'(rf_we), 32'd0);
    chk("ro_drop1", 32'(drop_count), 32'd1);
    b_valid = 1'b1; b_dreg = 4'd15; b_data = 32'h1515;
    settle();
    chk("ro_b_ready", 32'(b_ready), 32'd1);
    tick();
    b_valid = 1'b0;
    chk("ro_we15", 32'(rf_we), 32'd0);
    chk("ro_drop2", 32'(drop_count), 32'd2);
    chk("ro_dreg15", 32'(rf_dreg), 32'd15);
    issue_valid = 1'b1; issue_dreg = 4'd14; rd_op1 = 4'd14;
    tick();
    issue_valid = 1'b0;
    chk("ro_pending14", 32'(pending), 32'h0);
    chk("ro_hazard14", 32'(hazard1), 32'd0);
    a_valid = 1'b1; a_dreg = 4'd14;
    for (int i = 0; i < 298; i++) tick();
    a_valid = 1'b0;
    chk("ro_sat", 32'(drop_count), 32'd255);
    tick();
    chk("ro_sat_hold", 32'(drop_count), 32'd255);

    // Reset mid-operation, with the pointer first moved to B
    issue_valid = 1'b1; issue_dreg = 4'd6;
    a_valid = 1'b1; a_dreg = 4'd1; a_data = 32'h1;
    b_valid = 1'b1; b_dreg = 4'd2; b_data = 32'h2;
    settle();
    chk("mr_pre_a", 32'(a_ready), 32'd1);
    tick();
    issue_valid = 1'b0;
    chk("mr_pending6", 32'(pending), 32'h40);
    reset = 1'b1; a_dreg = 4'd7; a_data = 32'h7777;
    settle();
    chk("mr_a_ready", 32'(a_ready), 32'd0);
    chk("mr_b_ready", 32'(b_ready), 32'd0);
    tick();
    reset = 1'b0;
    chk("mr_we", 32'(rf_we), 32'd0);
    chk("mr_pending", 32'(pending), 32'h0);
    chk("mr_drop", 32'(drop_count), 32'd0);
    settle();
    chk("mr_ptr_a", 32'(a_ready), 32'd1);
    chk("mr_ptr_b", 32'(b_ready), 32'd0);
    tick();
    chk("mr_we_after", 32'(rf_we), 32'd1);
    chk("mr_dreg_after", 32'(rf_dreg), 32'd7);
    settle();
    chk("mr_next_b", 32'(b_ready), 32'd1);
    tick();
    a_valid = 1'b0; b_valid = 1'b0;

    // Loser holds its request and is served next
    a_valid = 1'b1; a_dreg = 4'd8; a_data = 32'hA8;
    b_valid = 1'b1; b_dreg = 4'd9; b_data = 32'hB9;
    settle();
    chk("hd_a_wins", 32'(a_ready), 32'd1);
    chk("hd_b_waits", 32'(b_ready), 32'd0);
    tick();
    a_valid = 1'b0;
    chk("hd_dreg8", 32'(rf_dreg), 32'd8);
    settle();
    chk("hd_b_ready", 32'(b_ready), 32'd1);
    tick();
    b_valid = 1'b0;
    chk("hd_we", 32'(rf_we), 32'd1);
    chk("hd_dreg9", 32'(rf_dreg), 32'd9);
    chk("hd_wdata", rf_wdata, 32'hB9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
